// File: rtl/sig_period_meter.sv
// Period meter for a slow asynchronous square wave, measured in clk cycles.
// Synchronises sig_in, strobes on rising edges and times successive edges.
module sig_period_meter #(
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             measuring
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_timeout;
    state_t                 r_state;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_s;
            r_edge <= w_s & ~r_prev;
        end
    end

    // Edge wins over a counter at max; enable low wins over an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_edge && enable) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= ST_MEASURE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_edge) begin
                        r_period  <= r_cnt;
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b0;
                        r_cnt     <= CNT_ONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign edge_pulse   = r_edge;
    assign period       = r_period;
    assign period_valid = r_valid;
    assign timeout      = r_timeout;
    assign measuring    = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_sig_period_meter.sv
// Bench for sig_period_meter: a 26-bit and an 8-bit instance share one
// stimulus and are compared every cycle with an edge-time reference model.
module tb_sig_period_meter;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic sig_in;

    logic        ep0, pv0, to0, ms0;
    logic [25:0] per0;
    logic        ep1, pv1, to1, ms1;
    logic [7:0]  per1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sig_period_meter #(.CNT_W(26), .SYNC_STAGES(2)) u_w26 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .edge_pulse(ep0), .period(per0), .period_valid(pv0),
        .timeout(to0), .measuring(ms0)
    );

    sig_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_w8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .edge_pulse(ep1), .period(per1), .period_valid(pv1),
        .timeout(to1), .measuring(ms1)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, obs, exp, $time);
        end
    endtask

    // Reference model: a rising edge arms a timer; the next edge closes it.
    longint cyc = 0;
    bit [3:0] m_h;
    bit       m_ep;
    longint   m_max[2] = '{64'd67108863, 64'd255};
    longint   m_a[2];
    longint   m_per[2];
    bit       m_armed[2];
    bit       m_to[2];
    bit       m_val[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h  = '0;
            m_ep = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_a[i]     = 0;
                m_per[i]   = 0;
                m_armed[i] = 1'b0;
                m_to[i]    = 1'b0;
                m_val[i]   = 1'b0;
            end
        end else begin
            bit ep_act;
            cyc++;
            ep_act = m_ep;
            m_h    = {m_h[2:0], sig_in};
            m_ep   = m_h[2] & ~m_h[3];
            for (int i = 0; i < 2; i++) begin
                m_val[i] = 1'b0;
                if (!enable) begin
                    m_armed[i] = 1'b0;
                end else if (ep_act) begin
                    if (m_armed[i]) begin
                        m_per[i] = cyc - m_a[i];
                        m_val[i] = 1'b1;
                        m_to[i]  = 1'b0;
                    end
                    m_armed[i] = 1'b1;
                    m_a[i]     = cyc;
                end else if (m_armed[i] && (cyc - m_a[i]) == m_max[i]) begin
                    m_to[i]    = 1'b1;
                    m_armed[i] = 1'b0;
                end
            end
        end
    end

    int ep_cnt = 0;

    always @(negedge clk) begin
        chk("edge26", ep0, m_ep);
        chk("per26", per0, m_per[0]);
        chk("val26", pv0, m_val[0]);
        chk("to26", to0, m_to[0]);
        chk("meas26", ms0, m_armed[0]);
        chk("edge8", ep1, m_ep);
        chk("per8", per1, m_per[1]);
        chk("val8", pv1, m_val[1]);
        chk("to8", to1, m_to[1]);
        chk("meas8", ms1, m_armed[1]);
        if (ep0) ep_cnt++;
    end

    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        sig_in = 1'b0;
        idle(3);
        chk("rst_per", per0, 0);
        chk("rst_meas", ms0, 0);
        #2 rst_n = 1'b1;
        idle(4);

        // 50% duty, period 32
        wave(16, 16, 5);
        chk("p32", per0, 32);
        chk("p32_to", to0, 0);

        // fastest legal wave, then a slow one
        wave(1, 1, 8);
        chk("p2", per0, 2);
        wave(500, 500, 3);
        chk("p1000", per0, 1000);

        // 8-bit instance times out while held low
        idle(300);
        chk("to8_set", to1, 1);
        chk("to8_meas", ms1, 0);
        wave(20, 20, 3);
        chk("p40_8", per1, 40);
        chk("p40_to8", to1, 0);

        // edge lands exactly on counter max
        wave(128, 127, 3);
        chk("p255", per1, 255);
        chk("p255_to", to1, 0);
        wave(128, 128, 3);

        // abort mid-period
        wave(16, 16, 4);
        sig_in = 1'b1;
        idle(8);
        enable = 1'b0;
        idle(8);
        sig_in = 1'b0;
        idle(16);
        sig_in = 1'b1;
        idle(16);
        sig_in = 1'b0;
        idle(4);
        chk("abort_per", per0, 32);
        chk("abort_meas", ms0, 0);
        enable = 1'b1;
        idle(12);
        wave(16, 16, 3);
        chk("rearm_per", per0, 32);

        // async reset mid-period, sig_in high at release
        wave(16, 16, 2);
        sig_in = 1'b1;
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_per", per0, 0);
        chk("arst_val", pv0, 0);
        chk("arst_meas", ms0, 0);
        chk("arst_edge", ep0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ep_cnt = 0;
        idle(12);
        chk("rel_edges", ep_cnt, 1);
        chk("rel_per", per0, 0);

        // randomized waves and enable gaps
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            wave($urandom_range(1, 60), $urandom_range(1, 200),
                 $urandom_range(1, 4));
        end
        enable = 1'b1;
        wave(30, 30, 3);
        chk("final_per", per0, 60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
